// File: rtl/ctrl_pkg.sv
// Shared types for the instruction control sequencer:
// opcode constants, FSM states and the decoded control bundle.
package ctrl_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOADR = 4'b0010;
    localparam logic [3:0] OP_NOP   = 4'b0011;

    typedef enum logic [1:0] {
        S_DECODE,
        S_ADDR,
        S_ISSUE
    } state_t;

    // set_* flags mark which retained fields an opcode overwrites
    typedef struct packed {
        logic [1:0] aa;
        logic [1:0] ab;
        logic [1:0] ad;
        logic       set_aa;
        logic       set_ab;
        logic       set_ad;
        logic       set_md;
        logic       wr;
        logic       mw;
        logic       md;
        logic       illegal;
        logic       is_mem;
        logic       uses_amem;
    } bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: first instruction byte to
// control bundle, including which retained fields get written.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [7:0] inst,
    output bundle_t    dec
);

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;

    assign op = inst[7:4];
    assign rd = inst[3:2];
    assign rs = inst[1:0];

    always_comb begin
        dec = '0;
        unique case (1'b1)
            op == OP_LOAD: begin
                dec.ad        = rd;
                dec.set_ad    = 1'b1;
                dec.wr        = 1'b1;
                dec.set_md    = 1'b1;
                dec.is_mem    = 1'b1;
                dec.uses_amem = 1'b1;
            end
            op == OP_STORE: begin
                dec.ab        = rd;
                dec.set_ab    = 1'b1;
                dec.mw        = 1'b1;
                dec.is_mem    = 1'b1;
                dec.uses_amem = 1'b1;
            end
            op == OP_LOADR: begin
                dec.ad        = rd;
                dec.set_ad    = 1'b1;
                dec.wr        = 1'b1;
                dec.set_md    = 1'b1;
                dec.uses_amem = 1'b1;
            end
            op == OP_NOP: begin
            end
            op[3:1] == 3'b100: begin
                dec.aa     = rd;
                dec.ad     = rd;
                dec.set_aa = 1'b1;
                dec.set_ad = 1'b1;
                dec.wr     = 1'b1;
                dec.md     = 1'b1;
                dec.set_md = 1'b1;
            end
            (op[3:1] == 3'b101) || (op[3:2] == 2'b01): begin
                dec.aa     = rd;
                dec.ad     = rd;
                dec.ab     = rs;
                dec.set_aa = 1'b1;
                dec.set_ab = 1'b1;
                dec.set_ad = 1'b1;
                dec.wr     = 1'b1;
                dec.md     = 1'b1;
                dec.set_md = 1'b1;
            end
            op[3:2] == 2'b11: begin
                dec.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Handshaked instruction sequencer: assembles opcode plus address
// extension bytes and issues one registered control bundle per instruction.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter  int ADDR_EXT_BYTES = 1,
    localparam int AMEM_W         = 2 + 8 * ADDR_EXT_BYTES
) (
    input  logic              m_clk,
    input  logic              rst_n,
    input  logic [7:0]        inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic              exec_ready,
    output logic              op_valid,
    output logic [1:0]        aa,
    output logic [1:0]        ab,
    output logic [1:0]        ad,
    output logic [AMEM_W-1:0] amem,
    output logic              wr,
    output logic              mw,
    output logic              md,
    output logic              illegal
);

    localparam int CNT_W =
        (ADDR_EXT_BYTES > 1) ? $clog2(ADDR_EXT_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(ADDR_EXT_BYTES - 1);

    state_t            state;
    state_t            state_nxt;
    bundle_t           dec;
    logic [CNT_W-1:0]  cnt;
    logic [AMEM_W-1:0] addr_sh;
    logic [AMEM_W-1:0] addr_nxt;
    logic              pend_wr;
    logic              pend_mw;
    logic              dec_take;
    logic              addr_take;
    logic              addr_done;
    logic              issue_go;
    logic              retire;
    logic              dec_unused;

    ctrl_decode u_decode (
        .inst (inst),
        .dec  (dec)
    );

    assign dec_unused = dec.uses_amem;

    // Partial address lives in a shadow so amem changes atomically
    always_comb begin
        addr_nxt = addr_sh;
        addr_nxt[2 + 8 * int'(cnt) +: 8] = inst;
    end

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) state <= S_DECODE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        inst_ready = 1'b0;
        dec_take   = 1'b0;
        addr_take  = 1'b0;
        addr_done  = 1'b0;
        issue_go   = 1'b0;
        retire     = 1'b0;
        unique case (state)
            S_DECODE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    dec_take = 1'b1;
                    if (dec.is_mem) begin
                        state_nxt = S_ADDR;
                    end else begin
                        state_nxt = S_ISSUE;
                        issue_go  = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    addr_take = 1'b1;
                    if (cnt == CNT_LAST) begin
                        addr_done = 1'b1;
                        issue_go  = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            default: state_nxt = S_DECODE;
        endcase
    end

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            addr_sh  <= '0;
            amem     <= '0;
            pend_wr  <= 1'b0;
            pend_mw  <= 1'b0;
            aa       <= 2'd0;
            ab       <= 2'd0;
            ad       <= 2'd0;
            md       <= 1'b1;
            op_valid <= 1'b0;
            wr       <= 1'b0;
            mw       <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (dec_take) begin
                if (dec.set_aa) aa <= dec.aa;
                if (dec.set_ab) ab <= dec.ab;
                if (dec.set_ad) ad <= dec.ad;
                if (dec.set_md) md <= dec.md;
                pend_wr <= dec.wr;
                pend_mw <= dec.mw;
                if (dec.is_mem) begin
                    cnt          <= '0;
                    addr_sh[1:0] <= inst[1:0];
                end
            end
            if (addr_take) begin
                addr_sh <= addr_nxt;
                cnt     <= cnt + CNT_W'(1);
            end
            if (addr_done) begin
                amem <= addr_nxt;
                cnt  <= '0;
            end
            // Non-memory ops issue straight from the decoder output
            if (issue_go) begin
                op_valid <= 1'b1;
                wr       <= dec_take ? dec.wr : pend_wr;
                mw       <= dec_take ? dec.mw : pend_mw;
                illegal  <= dec_take & dec.illegal;
            end else if (retire) begin
                op_valid <= 1'b0;
                wr       <= 1'b0;
                mw       <= 1'b0;
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: one instance with one extension
// byte, one with two, hand-computed expected bundles.
module tb_ctrl_sequencer;

    logic        m_clk;
    logic        rst_n;
    logic [7:0]  inst;
    logic        exec_ready;
    logic        v1, v2;

    logic        r1, o1, wr1, mw1, md1, il1;
    logic [1:0]  aa1, ab1, ad1;
    logic [9:0]  amem1;

    logic        r2, o2, wr2, mw2, md2, il2;
    logic [1:0]  aa2, ab2, ad2;
    logic [17:0] amem2;

    int n_vec;
    int n_err;

    ctrl_sequencer u_dut1 (
        .m_clk      (m_clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (v1),
        .inst_ready (r1),
        .exec_ready (exec_ready),
        .op_valid   (o1),
        .aa         (aa1),
        .ab         (ab1),
        .ad         (ad1),
        .amem       (amem1),
        .wr         (wr1),
        .mw         (mw1),
        .md         (md1),
        .illegal    (il1)
    );

    ctrl_sequencer #(.ADDR_EXT_BYTES(2)) u_dut2 (
        .m_clk      (m_clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (v2),
        .inst_ready (r2),
        .exec_ready (exec_ready),
        .op_valid   (o2),
        .aa         (aa2),
        .ab         (ab2),
        .ad         (ad2),
        .amem       (amem2),
        .wr         (wr2),
        .mw         (mw2),
        .md         (md2),
        .illegal    (il2)
    );

    initial m_clk = 1'b0;
    always #5 m_clk = ~m_clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge m_clk);
        #1;
        chk("excl1", 32'(r1 & o1), 32'd0);
        chk("excl2", 32'(r2 & o2), 32'd0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        inst       = 8'h00;
        exec_ready = 1'b1;
        v1         = 1'b0;
        v2         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("rst_ready",  32'(r1),    32'd1);
        chk("rst_valid",  32'(o1),    32'd0);
        chk("rst_wr",     32'(wr1),   32'd0);
        chk("rst_mw",     32'(mw1),   32'd0);
        chk("rst_ill",    32'(il1),   32'd0);
        chk("rst_md",     32'(md1),   32'd1);
        chk("rst_regs",   32'({aa1, ab1, ad1}), 32'd0);
        chk("rst_amem",   32'(amem1), 32'd0);

        // ADD 0xA6
        inst = 8'hA6; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("add_valid", 32'(o1),  32'd1);
        chk("add_ready", 32'(r1),  32'd0);
        chk("add_aa",    32'(aa1), 32'd1);
        chk("add_ad",    32'(ad1), 32'd1);
        chk("add_ab",    32'(ab1), 32'd2);
        chk("add_wr",    32'(wr1), 32'd1);
        chk("add_md",    32'(md1), 32'd1);
        chk("add_mw",    32'(mw1), 32'd0);
        step();
        chk("add_once",  32'(o1),  32'd0);
        chk("add_wr0",   32'(wr1), 32'd0);

        // STORE 0x1B, 0x5C
        inst = 8'h1B; v1 = 1'b1;
        step();
        chk("st_b1_valid", 32'(o1), 32'd0);
        chk("st_b1_ready", 32'(r1), 32'd1);
        inst = 8'h5C;
        step();
        v1 = 1'b0;
        chk("st_valid", 32'(o1),    32'd1);
        chk("st_ab",    32'(ab1),   32'd2);
        chk("st_mw",    32'(mw1),   32'd1);
        chk("st_wr",    32'(wr1),   32'd0);
        chk("st_amem",  32'(amem1), 32'h173);
        chk("st_ad",    32'(ad1),   32'd1);
        step();
        chk("st_once",  32'(o1),    32'd0);

        // INC 0x84 with a 3-cycle downstream stall
        inst = 8'h84; v1 = 1'b1; exec_ready = 1'b0;
        step();
        v1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("inc_valid", 32'(o1),  32'd1);
            chk("inc_ready", 32'(r1),  32'd0);
            chk("inc_aa",    32'(aa1), 32'd1);
            chk("inc_ad",    32'(ad1), 32'd1);
            chk("inc_wr",    32'(wr1), 32'd1);
            chk("inc_md",    32'(md1), 32'd1);
            chk("inc_ab",    32'(ab1), 32'd2);
            if (i == 3) exec_ready = 1'b1;
            step();
        end
        chk("inc_done", 32'(o1), 32'd0);

        // illegal 0xF0
        inst = 8'hF0; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("ill_valid", 32'(o1),  32'd1);
        chk("ill_flag",  32'(il1), 32'd1);
        chk("ill_wr",    32'(wr1), 32'd0);
        chk("ill_mw",    32'(mw1), 32'd0);
        step();
        chk("ill_clr",   32'(il1), 32'd0);

        // two extension bytes with gaps: LOAD 0x06, 0x34, 0x12
        inst = 8'h06; v2 = 1'b1;
        step();
        v2 = 1'b0;
        step();
        chk("ld2_gap_valid", 32'(o2), 32'd0);
        chk("ld2_gap_ready", 32'(r2), 32'd1);
        inst = 8'h34; v2 = 1'b1;
        step();
        v2 = 1'b0;
        chk("ld2_b2_valid", 32'(o2),    32'd0);
        chk("ld2_b2_amem",  32'(amem2), 32'd0);
        step();
        inst = 8'h12; v2 = 1'b1;
        step();
        v2 = 1'b0;
        chk("ld2_valid", 32'(o2),    32'd1);
        chk("ld2_ad",    32'(ad2),   32'd1);
        chk("ld2_wr",    32'(wr2),   32'd1);
        chk("ld2_md",    32'(md2),   32'd0);
        chk("ld2_mw",    32'(mw2),   32'd0);
        chk("ld2_amem",  32'(amem2), 32'h48D2);
        step();
        chk("ld2_once",  32'(o2),    32'd0);

        // LOADR 0x2C reuses the retained address
        inst = 8'h2C; v2 = 1'b1;
        chk("ldr_ready", 32'(r2), 32'd1);
        step();
        v2 = 1'b0;
        chk("ldr_valid", 32'(o2),    32'd1);
        chk("ldr_ad",    32'(ad2),   32'd3);
        chk("ldr_wr",    32'(wr2),   32'd1);
        chk("ldr_md",    32'(md2),   32'd0);
        chk("ldr_amem",  32'(amem2), 32'h48D2);
        chk("ldr_misc",  32'({il2, aa2, ab2}), 32'd0);
        step();

        // reset in the middle of a LOAD address
        inst = 8'h0D; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("rl_pre_amem", 32'(amem1), 32'h173);
        rst_n = 1'b0;
        #2;
        chk("rl_valid", 32'(o1),    32'd0);
        chk("rl_amem",  32'(amem1), 32'd0);
        chk("rl_wr",    32'(wr1),   32'd0);
        rst_n = 1'b1;
        step();
        chk("rl_idle",  32'(o1),    32'd0);
        chk("rl_ready", 32'(r1),    32'd1);
        inst = 8'h94; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("rl_dec_valid", 32'(o1),    32'd1);
        chk("rl_dec_aa",    32'(aa1),   32'd1);
        chk("rl_dec_ad",    32'(ad1),   32'd1);
        chk("rl_dec_wr",    32'(wr1),   32'd1);
        chk("rl_dec_mw",    32'(mw1),   32'd0);
        chk("rl_dec_amem",  32'(amem1), 32'd0);
        step();
        chk("rl_dec_done",  32'(o1),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
